// File: rtl/cm811_ram_check_sched_if.sv
// Signal bundle between the CM811 init sequencer / RAM checkers and the RAM check scheduler.
// master: scheduler side; slave: sequencer plus checker side.
interface cm811_ram_check_sched_if #(
    parameter int NUM_CH = 16
);
    logic              start;
    logic              abort;
    logic [NUM_CH-1:0] chan_en_mask;
    logic              busy;
    logic              run_done;
    logic              run_error;
    logic [NUM_CH-1:0] err_mask;
    logic [NUM_CH-1:0] timeout_mask;
    logic [3:0]        cur_ch;
    logic [NUM_CH-1:0] init_check_en;
    logic [NUM_CH-1:0] init_check_done;
    logic [NUM_CH-1:0] init_check_error;

    modport master (
        input  start,
        input  abort,
        input  chan_en_mask,
        input  init_check_done,
        input  init_check_error,
        output busy,
        output run_done,
        output run_error,
        output err_mask,
        output timeout_mask,
        output cur_ch,
        output init_check_en
    );

    modport slave (
        output start,
        output abort,
        output chan_en_mask,
        output init_check_done,
        output init_check_error,
        input  busy,
        input  run_done,
        input  run_error,
        input  err_mask,
        input  timeout_mask,
        input  cur_ch,
        input  init_check_en
    );
endinterface

// File: rtl/cm811_ram_check_sched.sv
// Launches the CM811 RAM self-check engines one at a time and collects error/timeout masks.
// Define CM811_RAM_CHECK_TIMEOUT_EN to build the per-channel WAIT timeout counter.
module cm811_ram_check_sched #(
    parameter int NUM_CH      = 16,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    sys_clk,
    input  logic                    glbl_rst_n,
    cm811_ram_check_sched_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

    if (NUM_CH < 2 || NUM_CH > 16 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
        $error("cm811_ram_check_sched: NUM_CH must be 2..16 and TIMEOUT_CYC 1..65535");
    end

    state_t            state_q, state_d;
    logic [3:0]        cur_ch_q, cur_ch_d;
    logic [NUM_CH-1:0] en_mask_q, en_mask_d;
    logic [NUM_CH-1:0] err_q, err_d;
    logic [NUM_CH-1:0] to_q, to_d;

    logic [NUM_CH-1:0] ch_sel;
    logic              ch_enabled;
    logic              ch_done;
    logic              ch_error;
    logic              ch_timeout;

    // Only the current channel's enable/done/error bit is ever looked at.
    always_comb begin
        ch_sel     = {{(NUM_CH-1){1'b0}}, 1'b1} << cur_ch_q;
        ch_enabled = |(en_mask_q & ch_sel);
        ch_done    = |(bus.init_check_done & ch_sel);
        ch_error   = |(bus.init_check_error & ch_sel);
    end

`ifdef CM811_RAM_CHECK_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
        if (!glbl_rst_n) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_LAUNCH) begin
            tmo_cnt_q <= '0;
        end else if (state_q == S_WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    always_comb ch_timeout = (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));
`else
    always_comb ch_timeout = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge glbl_rst_n) begin
        if (!glbl_rst_n) begin
            state_q   <= S_IDLE;
            cur_ch_q  <= '0;
            en_mask_q <= '0;
            err_q     <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            cur_ch_q  <= cur_ch_d;
            en_mask_q <= en_mask_d;
            err_q     <= err_d;
            to_q      <= to_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        cur_ch_d          = cur_ch_q;
        en_mask_d         = en_mask_q;
        err_d             = err_q;
        to_d              = to_q;
        bus.init_check_en = '0;
        bus.run_done      = 1'b0;
        bus.run_error     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    en_mask_d = bus.chan_en_mask;
                    err_d     = '0;
                    to_d      = '0;
                    cur_ch_d  = '0;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (ch_enabled) begin
                    bus.init_check_en = ch_sel;
                    state_d           = S_WAIT;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_WAIT: begin
                // A response in the last counted cycle still beats the timeout.
                if (ch_error) begin
                    err_d   = err_q | ch_sel;
                    state_d = S_NEXT;
                end else if (ch_done) begin
                    state_d = S_NEXT;
                end else if (ch_timeout) begin
                    err_d   = err_q | ch_sel;
                    to_d    = to_q | ch_sel;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (cur_ch_q == LAST_CH) begin
                    state_d = S_FINISH;
                end else begin
                    cur_ch_d = cur_ch_q + 4'd1;
                    state_d  = S_LAUNCH;
                end
            end
            S_FINISH: begin
                bus.run_done  = 1'b1;
                bus.run_error = |err_q;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a response arriving in the same cycle.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d           = S_IDLE;
            cur_ch_d          = cur_ch_q;
            en_mask_d         = en_mask_q;
            err_d             = err_q;
            to_d              = to_q;
            bus.init_check_en = '0;
            bus.run_done      = 1'b0;
            bus.run_error     = 1'b0;
        end
    end

    always_comb begin
        bus.busy         = (state_q != S_IDLE);
        bus.cur_ch       = cur_ch_q;
        bus.err_mask     = err_q;
        bus.timeout_mask = to_q;
    end

    a_launch_onehot: assert property (@(posedge sys_clk) disable iff (!glbl_rst_n)
        $onehot0(bus.init_check_en));
    a_error_with_done: assert property (@(posedge sys_clk) disable iff (!glbl_rst_n)
        bus.run_error |-> bus.run_done);

endmodule

// File: tb/tb_cm811_ram_check_sched.sv
// Randomized bench for cm811_ram_check_sched: a per-run plan is turned into an expected
// cycle-by-cycle schedule by arithmetic, and checker responses are played back from it.
module tb_cm811_ram_check_sched;

    localparam int NUM_CH = 16;
    localparam int TMO    = 8;

    logic sys_clk;
    logic glbl_rst_n;
    int   n_chk;
    int   n_fail;

    // Plan: per channel response kind (0 done, 1 error, 2 error+done, 3 silent) and delay.
    logic [NUM_CH-1:0] p_en;
    int p_type    [NUM_CH];
    int p_dly     [NUM_CH];
    int m_launch  [NUM_CH];
    int m_resolve [NUM_CH];
    int m_finish;

    cm811_ram_check_sched_if #(.NUM_CH(NUM_CH)) bus ();

    cm811_ram_check_sched #(
        .NUM_CH      (NUM_CH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .sys_clk    (sys_clk),
        .glbl_rst_n (glbl_rst_n),
        .bus        (bus)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, summary not printed");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"},      32'(bus.busy),          32'd0);
        check({tag, ".run_done"},  32'(bus.run_done),      32'd0);
        check({tag, ".run_error"}, 32'(bus.run_error),     32'd0);
        check({tag, ".err_mask"},  32'(bus.err_mask),      32'd0);
        check({tag, ".to_mask"},   32'(bus.timeout_mask),  32'd0);
        check({tag, ".cur_ch"},    32'(bus.cur_ch),        32'd0);
        check({tag, ".en"},        32'(bus.init_check_en), 32'd0);
    endtask

    // Cycle 0 is the first cycle after the start edge; each enabled channel takes
    // launch + wait + next, a disabled one takes 2 cycles.
    task automatic model_run();
        int t;
        t = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (p_en[i]) begin
                m_launch[i]  = t;
                m_resolve[i] = t + ((p_type[i] == 3) ? TMO : p_dly[i]);
                t            = m_resolve[i] + 2;
            end else begin
                m_launch[i]  = -1;
                m_resolve[i] = -1;
                t            = t + 2;
            end
        end
        m_finish = t;
    endtask

    task automatic set_all(input int kind, input int dly);
        p_en = '1;
        for (int i = 0; i < NUM_CH; i++) begin
            p_type[i] = kind;
            p_dly[i]  = dly;
        end
    endtask

    task automatic random_plan();
        p_en = NUM_CH'($urandom);
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef CM811_RAM_CHECK_TIMEOUT_EN
            p_type[i] = int'($urandom_range(0, 3));
`else
            p_type[i] = int'($urandom_range(0, 2));
`endif
            p_dly[i] = int'($urandom_range(1, 6));
        end
    endtask

    task automatic do_run(input int abort_at, input int rst_at, input int start_hold, input bit noise);
        logic [NUM_CH-1:0] exp_err, exp_to, exp_en, drv_done, drv_err, quiet;
        int last, exp_ch;
        bit ended, fin;
        model_run();
        last    = (abort_at >= 0) ? abort_at : m_finish;
        exp_err = '0;
        exp_to  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (p_en[i] && p_type[i] != 0 && (abort_at < 0 || m_resolve[i] < abort_at)) begin
                exp_err[i] = 1'b1;
                exp_to[i]  = (p_type[i] == 3);
            end
        end

        @(negedge sys_clk);
        bus.chan_en_mask = p_en;
        bus.start        = 1'b1;
        ended            = 1'b0;
        for (int n = 0; n <= last + 2 && !ended; n++) begin
            @(negedge sys_clk);
            if (n == rst_at) begin
                glbl_rst_n           = 1'b0;
                bus.start            = 1'b0;
                bus.abort            = 1'b0;
                bus.init_check_done  = '0;
                bus.init_check_error = '0;
                #1 check_zero($sformatf("rst_mid@%0d", n));
                @(negedge sys_clk);
                glbl_rst_n = 1'b1;
                ended      = 1'b1;
            end else begin
                exp_en = '0;
                exp_ch = -1;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_launch[i] == n) begin
                        exp_en[i] = 1'b1;
                        exp_ch    = i;
                    end
                end
                if (n == abort_at) exp_en = '0;
                fin = (abort_at < 0) && (n == m_finish);
                check($sformatf("busy@%0d", n),      32'(bus.busy),          32'(n <= last));
                check($sformatf("en@%0d", n),        32'(bus.init_check_en), 32'(exp_en));
                check($sformatf("run_done@%0d", n),  32'(bus.run_done),      32'(fin));
                check($sformatf("run_error@%0d", n), 32'(bus.run_error),     32'(fin && exp_err != '0));
                if (n == 0) begin
                    check("start_clr.err_mask", 32'(bus.err_mask),     32'd0);
                    check("start_clr.to_mask",  32'(bus.timeout_mask), 32'd0);
                end
                if (exp_en != '0) check($sformatf("cur_ch@%0d", n), 32'(bus.cur_ch), 32'(exp_ch));

                if (n == 1) bus.chan_en_mask = NUM_CH'($urandom);
                bus.start = (n < start_hold) && (n <= last);
                bus.abort = (n == abort_at);
                drv_done  = '0;
                drv_err   = '0;
                quiet     = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (p_en[i] && p_type[i] != 3 && m_launch[i] + p_dly[i] == n) begin
                        drv_done[i] = (p_type[i] != 1);
                        drv_err[i]  = (p_type[i] != 0);
                    end
                    if (p_en[i] && n > m_launch[i] && n <= m_resolve[i]) quiet[i] = 1'b1;
                end
                if (noise) begin
                    drv_done = drv_done | (NUM_CH'($urandom) & ~quiet);
                    drv_err  = drv_err  | (NUM_CH'($urandom) & ~quiet);
                end
                if (n > last) begin
                    drv_done = '0;
                    drv_err  = '0;
                end
                bus.init_check_done  = drv_done;
                bus.init_check_error = drv_err;
            end
        end
        if (!ended) begin
            check("end.err_mask", 32'(bus.err_mask),     32'(exp_err));
            check("end.to_mask",  32'(bus.timeout_mask), 32'(exp_to));
            if (abort_at < 0) check("end.cur_ch", 32'(bus.cur_ch), 32'(NUM_CH - 1));
        end
    endtask

    initial begin
        n_chk                = 0;
        n_fail               = 0;
        glbl_rst_n           = 1'b0;
        bus.start            = 1'b0;
        bus.abort            = 1'b0;
        bus.chan_en_mask     = '0;
        bus.init_check_done  = '0;
        bus.init_check_error = '0;
        repeat (2) @(negedge sys_clk);
        check_zero("reset");
        glbl_rst_n = 1'b1;

        // All channels pass after 3 cycles.
        set_all(0, 3);
        do_run(-1, -1, 0, 1'b0);

        // Channel 5 reports error and done together.
        set_all(0, 2);
        p_type[5] = 2;
        do_run(-1, -1, 0, 1'b1);

`ifdef CM811_RAM_CHECK_TIMEOUT_EN
        // Channel 9 never answers.
        set_all(0, 1);
        p_type[9] = 3;
        do_run(-1, -1, 0, 1'b0);
`endif

        // Only the end channels enabled, with stray responses elsewhere.
        set_all(0, 2);
        p_en = 16'h8001;
        do_run(-1, -1, 0, 1'b1);

        // Abort two cycles into the wait on channel 3; channel 1 has already failed.
        set_all(0, 4);
        p_type[1] = 1;
        model_run();
        do_run(m_launch[3] + 2, -1, 0, 1'b0);

        // Reset in the middle of a run.
        random_plan();
        do_run(-1, 20, 0, 1'b1);

        // Start held high through a whole run.
        random_plan();
        do_run(-1, -1, 1000, 1'b1);

        repeat (25) begin
            random_plan();
            do_run(-1, -1, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
